easyaxi_rd_arb: RTL and testbench



---
 rtl/easyaxi_rd_arb_pkg.sv | 19 +
 rtl/easyaxi_rd_arb_if.sv | 38 +++
 rtl/easyaxi_rr_arb2.sv | 21 ++
 rtl/easyaxi_rd_arb.sv | 145 ++++++++++++++
 tb/tb_easyaxi_rd_arb.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/easyaxi_rd_arb_pkg.sv
// rtl/easyaxi_rd_arb_pkg.sv - shared AXI read-channel widths and arbiter FSM encoding
package easyaxi_rd_arb_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;
  localparam int AXI_USER_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/easyaxi_rd_arb_if.sv
// rtl/easyaxi_rd_arb_if.sv - AXI read address + read data channel bundle
interface easyaxi_rd_arb_if
  import easyaxi_rd_arb_pkg::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int LEN_W  = AXI_LEN_W
) ();

  logic                   arvalid;
  logic                   arready;
  logic [ID_W-1:0]        arid;
  logic [ADDR_W-1:0]      araddr;
  logic [LEN_W-1:0]       arlen;
  logic [AXI_SIZE_W-1:0]  arsize;
  logic [AXI_BURST_W-1:0] arburst;
  logic [AXI_USER_W-1:0]  aruser;

  logic                   rvalid;
  logic                   rready;
  logic [ID_W-1:0]        rid;
  logic [DATA_W-1:0]      rdata;
  logic [AXI_RESP_W-1:0]  rresp;
  logic                   rlast;
  logic [AXI_USER_W-1:0]  ruser;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, aruser, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast, ruser
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, aruser, rready,
    output arready, rvalid, rid, rdata, rresp, rlast, ruser
  );

endinterface

// File: rtl/easyaxi_rr_arb2.sv
// rtl/easyaxi_rr_arb2.sv - two-requester round-robin pick, purely combinational
module easyaxi_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // last_gnt_i is the index of the master served most recently; a tie goes to the other one
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&req_i) begin
        gnt_o = last_gnt_i ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

endmodule

// File: rtl/easyaxi_rd_arb.sv
// rtl/easyaxi_rd_arb.sv - two-master AXI read arbiter, one burst in flight, beat-count check
module easyaxi_rd_arb
  import easyaxi_rd_arb_pkg::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int LEN_W  = AXI_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  easyaxi_rd_arb_if.slave  mst0_if,
  easyaxi_rd_arb_if.slave  mst1_if,
  easyaxi_rd_arb_if.master slv_if,
  output logic [1:0]       arb_gnt_o,
  output logic             arb_busy_o,
  output logic             arb_len_err_o
);

  arb_state_e       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d, rr_gnt;
  logic             last_gnt_q, last_gnt_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             len_err_q, len_err_d;

  logic              sel, ar_req, r_rready, ar_hs, r_hs, beat_sat;
  logic [ID_W-1:0]   arid_mux;
  logic [ADDR_W-1:0] araddr_mux;
  logic [LEN_W-1:0]  arlen_mux;
  logic [DATA_W-1:0] rdata_bc;

  easyaxi_rr_arb2 u_rr (
    .req_i      ({mst1_if.arvalid, mst0_if.arvalid}),
    .last_gnt_i (last_gnt_q),
    .en_i       (state_q == ST_IDLE),
    .gnt_o      (rr_gnt)
  );

  // gnt_q is zero in IDLE, so the payload mux rests on master 0
  assign sel        = gnt_q[1];
  assign arid_mux   = sel ? mst1_if.arid   : mst0_if.arid;
  assign araddr_mux = sel ? mst1_if.araddr : mst0_if.araddr;
  assign arlen_mux  = sel ? mst1_if.arlen  : mst0_if.arlen;
  assign ar_req     = sel ? mst1_if.arvalid : mst0_if.arvalid;
  assign r_rready   = sel ? mst1_if.rready  : mst0_if.rready;

  assign slv_if.arid    = arid_mux;
  assign slv_if.araddr  = araddr_mux;
  assign slv_if.arlen   = arlen_mux;
  assign slv_if.arsize  = sel ? mst1_if.arsize  : mst0_if.arsize;
  assign slv_if.arburst = sel ? mst1_if.arburst : mst0_if.arburst;
  assign slv_if.aruser  = sel ? mst1_if.aruser  : mst0_if.aruser;

  assign slv_if.arvalid  = (state_q == ST_AR) && ar_req;
  assign mst0_if.arready = (state_q == ST_AR) && gnt_q[0] && slv_if.arready;
  assign mst1_if.arready = (state_q == ST_AR) && gnt_q[1] && slv_if.arready;
  assign ar_hs           = slv_if.arvalid && slv_if.arready;

  assign slv_if.rready  = (state_q == ST_R) && r_rready;
  assign mst0_if.rvalid = (state_q == ST_R) && gnt_q[0] && slv_if.rvalid;
  assign mst1_if.rvalid = (state_q == ST_R) && gnt_q[1] && slv_if.rvalid;
  assign r_hs           = slv_if.rvalid && slv_if.rready;

  assign rdata_bc      = slv_if.rdata;
  assign mst0_if.rid   = slv_if.rid;
  assign mst0_if.rdata = rdata_bc;
  assign mst0_if.rresp = slv_if.rresp;
  assign mst0_if.rlast = slv_if.rlast;
  assign mst0_if.ruser = slv_if.ruser;
  assign mst1_if.rid   = slv_if.rid;
  assign mst1_if.rdata = rdata_bc;
  assign mst1_if.rresp = slv_if.rresp;
  assign mst1_if.rlast = slv_if.rlast;
  assign mst1_if.ruser = slv_if.ruser;

  assign beat_sat = &beat_cnt_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    len_err_d  = len_err_q;
    case (state_q)
      ST_IDLE: begin
        if (|rr_gnt) begin
          gnt_d   = rr_gnt;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (ar_hs) begin
          len_d      = arlen_mux;
          beat_cnt_d = '0;
          state_d    = ST_R;
        end
      end
      ST_R: begin
        if (r_hs) begin
          if (!beat_sat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          // beat_cnt_q counts beats before this one, so the last beat must land on len_q
          if (slv_if.rlast ? (beat_cnt_q != len_q) : ((beat_cnt_q == len_q) || beat_sat)) begin
            len_err_d = 1'b1;
          end
          if (slv_if.rlast) begin
            last_gnt_d = sel;
            gnt_d      = 2'b00;
            state_d    = ST_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 2'b00;
      last_gnt_q <= 1'b1;
      beat_cnt_q <= '0;
      len_q      <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      len_err_q  <= len_err_d;
    end
  end

  assign arb_gnt_o     = gnt_q;
  assign arb_busy_o    = (state_q != ST_IDLE);
  assign arb_len_err_o = len_err_q;

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// tb/tb_easyaxi_rd_arb.sv - directed and randomized bursts against a burst-level reference model
module tb_easyaxi_rd_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] arb_gnt;
  logic       arb_busy, arb_len_err;

  always #5 clk = ~clk;

  easyaxi_rd_arb_if m0 ();
  easyaxi_rd_arb_if m1 ();
  easyaxi_rd_arb_if s ();

  easyaxi_rd_arb dut (
    .clk           (clk),
    .rst           (rst),
    .mst0_if       (m0),
    .mst1_if       (m1),
    .slv_if        (s),
    .arb_gnt_o     (arb_gnt),
    .arb_busy_o    (arb_busy),
    .arb_len_err_o (arb_len_err)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  bit          pend [2];
  bit          prr [2];
  logic [7:0]  plen [2];
  logic [31:0] paddr [2];
  logic [3:0]  pid [2];
  int          exp_last;
  bit          exp_err;
  logic [1:0]  g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    m0.arvalid = pend[0]; m0.arid = pid[0]; m0.araddr = paddr[0]; m0.arlen = plen[0];
    m0.arsize = 3'd2; m0.arburst = 2'b01; m0.aruser = 4'h0; m0.rready = prr[0];
    m1.arvalid = pend[1]; m1.arid = pid[1]; m1.araddr = paddr[1]; m1.arlen = plen[1];
    m1.arsize = 3'd2; m1.arburst = 2'b01; m1.aruser = 4'h1; m1.rready = prr[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int m);
    pend[m]  = 1'b1;
    plen[m]  = 8'($urandom_range(0, 4));
    paddr[m] = $urandom;
    pid[m]   = 4'($urandom);
  endtask

  // Both requesting: the one not served last wins; otherwise the lone requester
  function automatic int winner();
    if (pend[0] && pend[1]) return 1 - exp_last;
    return pend[1] ? 1 : 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; pend = '{1'b0, 1'b0}; prr = '{1'b0, 1'b0};
    s.rvalid = 1'b0; s.arready = 1'b0;
    drive();
    tick();
    rst = 1'b0; exp_last = 1; exp_err = 1'b0;
  endtask

  // nb: beats the slave returns (0 = arlen+1, <0 = random, mostly correct)
  task automatic do_burst(input int nb, input int abort_at, input int ar_wait, output logic [1:0] g_obs);
    int w, L, hs, rx;
    logic [31:0] d;
    bit rv;
    hs = 0; rx = 0; g_obs = 2'b00;
    drive(); #1;
    check("idle_gnt", 64'(arb_gnt), 64'(0));
    check("idle_arvalid", 64'(s.arvalid), 64'(0));
    w = winner(); L = int'(plen[w]);
    if (nb < 0) nb = ($urandom_range(0, 4) != 0) ? L + 1 : ((($urandom_range(0, 1) != 0) || L == 0) ? L + 2 : L);
    else if (nb == 0) nb = L + 1;
    tick();
    for (int c = 0; c <= ar_wait; c++) begin
      s.arready = (c == ar_wait); drive(); #1;
      if (c == 0) g_obs = arb_gnt;
      check("ar_gnt", 64'(arb_gnt), 64'((w == 0) ? 2'b01 : 2'b10));
      check("ar_valid", 64'(s.arvalid), 64'(1));
      check("ar_payload", 64'({s.arid, s.arlen, s.araddr}), 64'({pid[w], plen[w], paddr[w]}));
      check("ar_ready", 64'({m1.arready, m0.arready}),
            64'((c == ar_wait) ? ((w == 0) ? 2'b01 : 2'b10) : 2'b00));
      tick();
    end
    s.arready = 1'b0; pend[w] = 1'b0;
    for (int cyc = 0; hs < nb && cyc < 200; cyc++) begin
      rv = ($urandom_range(0, 3) != 0);
      s.rvalid = rv; prr[w] = ($urandom_range(0, 2) != 0); prr[1-w] = ($urandom_range(0, 1) != 0);
      d = $urandom; s.rdata = d; s.rid = pid[w]; s.rlast = (hs == nb - 1);
      drive(); #1;
      check("r_valid", 64'({m1.rvalid, m0.rvalid}), 64'(rv ? ((w == 0) ? 2'b01 : 2'b10) : 2'b00));
      check("r_ready", 64'(s.rready), 64'(prr[w]));
      check("r_data_bcast", {m1.rdata, m0.rdata}, {d, d});
      check("r_arready", 64'({m1.arready, m0.arready}), 64'(0));
      if (((w == 0) ? m0.rvalid : m1.rvalid) && prr[w]) rx++;
      if (rv && prr[w]) hs++;
      tick();
      if (abort_at > 0 && hs == abort_at) begin
        rst = 1'b1; s.rvalid = 1'b0; pend = '{1'b0, 1'b0}; prr = '{1'b0, 1'b0};
        drive();
        tick();
        rst = 1'b0; drive(); #1;
        check("rst_gnt", 64'(arb_gnt), 64'(0));
        check("rst_busy", 64'(arb_busy), 64'(0));
        check("rst_len_err", 64'(arb_len_err), 64'(0));
        check("rst_arvalid", 64'(s.arvalid), 64'(0));
        exp_last = 1; exp_err = 1'b0;
        return;
      end
    end
    if (hs < nb) check("r_timeout", 64'(hs), 64'(nb));
    check("beats_rx", 64'(rx), 64'(nb));
    exp_err = exp_err | (nb != L + 1);
    exp_last = w;
    s.rvalid = 1'b0; s.rlast = 1'b0; prr = '{1'b0, 1'b0};
    drive(); #1;
    check("done_busy", 64'(arb_busy), 64'(0));
    check("len_err", 64'(arb_len_err), 64'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; exp_last = 1; exp_err = 1'b0;
    pend = '{1'b0, 1'b0}; prr = '{1'b0, 1'b0};
    plen = '{8'd0, 8'd0}; pid = '{4'd0, 4'd0}; paddr = '{32'hA5A5_0000, 32'h5A5A_0000};
    s.arready = 1'b0; s.rvalid = 1'b0; s.rid = 4'd0; s.rdata = 32'd0;
    s.rresp = 2'b00; s.rlast = 1'b0; s.ruser = 4'h0;
    drive();
    tick(); tick();
    check("reset_gnt", 64'(arb_gnt), 64'(0));
    check("reset_busy", 64'(arb_busy), 64'(0));
    check("reset_len_err", 64'(arb_len_err), 64'(0));
    check("reset_valids", 64'({s.arvalid, s.rready, m0.arready, m1.arready, m0.rvalid, m1.rvalid}), 64'(0));
    check("reset_payload_mux", 64'(s.araddr), 64'(32'hA5A5_0000));
    rst = 1'b0;

    // stray R beat while idle
    s.rvalid = 1'b1; s.rlast = 1'b1; drive(); #1;
    check("stray_rready", 64'(s.rready), 64'(0));
    check("stray_mst_rvalid", 64'({m1.rvalid, m0.rvalid}), 64'(0));
    tick();
    s.rvalid = 1'b0; s.rlast = 1'b0; drive(); #1;
    check("stray_busy", 64'(arb_busy), 64'(0));

    // single request, arlen=3, four beats
    pend[0] = 1'b1; plen[0] = 8'd3; paddr[0] = 32'h0000_1000; pid[0] = 4'd1;
    do_burst(4, 0, 0, g);
    check("single_gnt", 64'(g), 64'(2'b01));

    // AR backpressure for 5 cycles
    pend[0] = 1'b1; plen[0] = 8'd2; paddr[0] = 32'h0000_2000; pid[0] = 4'd2;
    do_burst(0, 0, 5, g);

    // arlen=1, rlast on first beat: sticky error
    pend[0] = 1'b1; plen[0] = 8'd1; paddr[0] = 32'h0000_3000;
    do_burst(1, 0, 0, g);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("err_sticky", 64'(arb_len_err), 64'(1));
    end
    do_reset(); #1;
    check("reset_err_clear", 64'(arb_len_err), 64'(0));

    // arlen=1, rlast on third beat: error, still returns to IDLE
    pend[1] = 1'b1; plen[1] = 8'd1; paddr[1] = 32'h0000_4000; pid[1] = 4'd4;
    do_burst(3, 0, 0, g);
    check("long_burst_gnt", 64'(g), 64'(2'b10));

    // reset after beat 2 of 4
    pend[0] = 1'b1; plen[0] = 8'd3; paddr[0] = 32'h0000_5000;
    do_burst(4, 2, 0, g);

    // both masters held requesting: strict alternation starting with master 0
    for (int i = 0; i < 4; i++) begin
      if (!pend[0]) new_req(0);
      if (!pend[1]) new_req(1);
      do_burst(0, 0, 0, g);
      check("alt_order", 64'(g), 64'(((i % 2) == 1) ? 2'b10 : 2'b01));
    end

    for (int i = 0; i < 30; i++) begin
      if (!pend[0] && ($urandom_range(0, 1) != 0)) new_req(0);
      if (!pend[1] && ($urandom_range(0, 1) != 0)) new_req(1);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      do_burst(-1, 0, int'($urandom_range(0, 3)), g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
